// File: rtl/div_pkg.sv
// Shared constants, state encoding and the 4-bit carry-lookahead block
// used by the unsigned divider datapath.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  // Carries out of bits 0..3 of a 4-bit group, all computed from the group carry-in.
  function automatic logic [3:0] cla4_carry(input logic [3:0] g,
                                            input logic [3:0] p,
                                            input logic       c0);
    logic [3:0] c;
    c[0] = g[0] | (p[0] & c0);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

endpackage

// File: rtl/addsub_cla33.sv
// WIDTH+1-bit add/subtract built from 4-bit CLA groups; subtract inverts y
// and injects a carry-in of 1. WIDTH must be a multiple of 4.
module addsub_cla33
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0] x,
  input  logic [WIDTH:0] y,
  input  logic           sub,
  output logic [WIDTH:0] s
);

  logic [WIDTH:0] w_y;
  logic [WIDTH:0] w_p;
  logic [WIDTH:0] w_g;
  logic [WIDTH:0] w_c;

  assign w_y    = y ^ {(WIDTH + 1){sub}};
  assign w_p    = x ^ w_y;
  assign w_g    = x & w_y;
  assign w_c[0] = sub;

  // Group k produces the carries into bits 4k+1..4k+4; the last one feeds the sign bit.
  for (genvar gi = 0; gi < WIDTH / 4; gi++) begin : g_cla
    assign w_c[4*gi+4 : 4*gi+1] = cla4_carry(w_g[4*gi +: 4], w_p[4*gi +: 4], w_c[4*gi]);
  end

  assign s = w_p ^ w_c;

endmodule

// File: rtl/udiv32_nonrestoring.sv
// Multicycle unsigned divider: one non-restoring quotient bit per clock,
// a single remainder-correction cycle, and a b==0 fast path.
module udiv32_nonrestoring
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             ready,
  output logic             div_by_zero
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_t       r_state;
  logic [WIDTH:0]   r_rem;    // two's-complement partial remainder, bit WIDTH is the sign
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH:0]   w_x;
  logic [WIDTH:0]   w_y;
  logic             w_sub;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_fix_r;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_x   = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    w_sub = ~r_rem[WIDTH];
    if (r_state == FIX) begin
      w_x   = r_rem;
      w_sub = 1'b0;
    end
  end

  assign w_y     = {1'b0, r_dvs};
  assign w_fix_r = r_rem[WIDTH] ? w_sum[WIDTH-1:0] : r_rem[WIDTH-1:0];

  addsub_cla33 #(.WIDTH(WIDTH)) u_addsub (
    .x   (w_x),
    .y   (w_y),
    .sub (w_sub),
    .s   (w_sum)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_cnt       <= '0;
      q           <= '0;
      r           <= '0;
      busy        <= 1'b0;
      ready       <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      ready <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            if (b != '0) begin
              r_quo   <= a;
              r_dvs   <= b;
              r_rem   <= '0;
              r_cnt   <= '0;
              busy    <= 1'b1;
              r_state <= ITER;
            end else begin
              q           <= '1;
              r           <= a;
              div_by_zero <= 1'b1;
              ready       <= 1'b1;
            end
          end
        end
        ITER: begin
          r_rem <= w_sum;
          r_quo <= {r_quo[WIDTH-2:0], ~w_sum[WIDTH]};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_STEP) r_state <= FIX;
        end
        FIX: begin
          if (r_rem[WIDTH]) r_rem <= w_sum;
          q           <= r_quo;
          r           <= w_fix_r;
          div_by_zero <= 1'b0;
          ready       <= 1'b1;
          busy        <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udiv32_nonrestoring.sv
// Directed-vector and sequence bench for udiv32_nonrestoring.
module tb_udiv32_nonrestoring;
  import div_pkg::*;

  localparam int W          = DIV_WIDTH;
  localparam int NORMAL_LAT = W + 2;
  localparam int TIMEOUT    = 100;
  localparam int N_RANDOM   = 1500;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] q_o;
  logic [W-1:0] r_o;
  logic         busy;
  logic         ready;
  logic         div_by_zero;

  int errors = 0;
  int checks = 0;

  udiv32_nonrestoring #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .q           (q_o),
    .r           (r_o),
    .busy        (busy),
    .ready       (ready),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to the next cycle; outputs are observed 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation in the current cycle and wait for its ready pulse.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        output logic [W-1:0] oq, output logic [W-1:0] orr,
                        output logic odbz, output int lat, output logic saw_busy);
    a        = ia;
    b        = ib;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    lat      = 1;
    saw_busy = busy;
    while (ready !== 1'b1 && lat < TIMEOUT) begin
      tick();
      lat++;
      saw_busy |= busy;
    end
    if (ready !== 1'b1) check("ready_timeout", 64'(ready), 64'(1));
    oq   = q_o;
    orr  = r_o;
    odbz = div_by_zero;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t         vecs[$];
    logic [W-1:0] gq, gr;
    logic         gdbz, sb;
    int           lat, pulses, ready_cyc;
    logic [W-1:0] pq, pr;

    vecs.push_back('{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2,          dbz: 1'b0});
    vecs.push_back('{a: 32'hFFFF_FFFF,  b: 32'd1,          q: 32'hFFFF_FFFF,  r: 32'd0,          dbz: 1'b0});
    vecs.push_back('{a: 32'd3,          b: 32'd10,         q: 32'd0,          r: 32'd3,          dbz: 1'b0});
    vecs.push_back('{a: 32'h8000_0000,  b: 32'hFFFF_FFFF,  q: 32'd0,          r: 32'h8000_0000,  dbz: 1'b0});
    vecs.push_back('{a: 32'd5,          b: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'd5,          dbz: 1'b1});
    vecs.push_back('{a: 32'd9,          b: 32'd3,          q: 32'd3,          r: 32'd0,          dbz: 1'b0});
    vecs.push_back('{a: 32'd0,          b: 32'd5,          q: 32'd0,          r: 32'd0,          dbz: 1'b0});
    vecs.push_back('{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  q: 32'd1,          r: 32'd0,          dbz: 1'b0});
    vecs.push_back('{a: 32'hDEAD_BEEF,  b: 32'h10,         q: 32'h0DEA_DBEE,  r: 32'hF,          dbz: 1'b0});
    vecs.push_back('{a: 32'd6,          b: 32'd7,          q: 32'd0,          r: 32'd6,          dbz: 1'b0});
    vecs.push_back('{a: 32'd7,          b: 32'd7,          q: 32'd1,          r: 32'd0,          dbz: 1'b0});
    vecs.push_back('{a: 32'd0,          b: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'd0,          dbz: 1'b1});

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    check("reset_q", 64'(q_o), 64'(0));
    check("reset_r", 64'(r_o), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_ready", 64'(ready), 64'(0));
    check("reset_dbz", 64'(div_by_zero), 64'(0));

    // 100/7 with cycle-accurate busy/ready checks
    a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= W + 1; c++) begin
      check($sformatf("busy_c%0d", c), 64'(busy), 64'(1));
      check($sformatf("noready_c%0d", c), 64'(ready), 64'(0));
      tick();
    end
    check("lat_ready", 64'(ready), 64'(1));
    check("lat_busy_low", 64'(busy), 64'(0));
    check("lat_q", 64'(q_o), 64'(14));
    check("lat_r", 64'(r_o), 64'(2));
    check("lat_dbz", 64'(div_by_zero), 64'(0));
    tick();
    check("ready_single_pulse", 64'(ready), 64'(0));
    check("q_hold", 64'(q_o), 64'(14));

    // Table vectors, issued back to back in each ready cycle
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, gq, gr, gdbz, lat, sb);
      check($sformatf("vec%0d_q", i), 64'(gq), 64'(vecs[i].q));
      check($sformatf("vec%0d_r", i), 64'(gr), 64'(vecs[i].r));
      check($sformatf("vec%0d_dbz", i), 64'(gdbz), 64'(vecs[i].dbz));
      check($sformatf("vec%0d_lat", i), 64'(lat), vecs[i].dbz ? 64'(1) : 64'(NORMAL_LAT));
      if (vecs[i].dbz) check($sformatf("vec%0d_no_busy", i), 64'(sb), 64'(0));
    end
    tick();
    check("hold_after_dbz_ready", 64'(ready), 64'(0));
    check("hold_after_dbz_q", 64'(q_o), 64'hFFFF_FFFF);
    check("hold_after_dbz_flag", 64'(div_by_zero), 64'(1));

    // Start while busy is ignored
    tick();
    a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0; ready_cyc = -1; pq = '0; pr = '0;
    for (int c = 1; c <= 40; c++) begin
      if (ready) begin
        pulses++;
        ready_cyc = c;
        pq = q_o;
        pr = r_o;
      end
      if (c == 10) begin
        a = 32'd1; b = 32'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    check("ign_pulses", 64'(pulses), 64'(1));
    check("ign_ready_cycle", 64'(ready_cyc), 64'(NORMAL_LAT));
    check("ign_q", 64'(pq), 64'(14));
    check("ign_r", 64'(pr), 64'(2));

    // Reset mid-ITER, with a start offered in the reset cycle
    a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    rst = 1'b1; start = 1'b1; a = 32'd20; b = 32'd6;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ready", 64'(ready), 64'(0));
    check("rst_q", 64'(q_o), 64'(0));
    check("rst_r", 64'(r_o), 64'(0));
    check("rst_dbz", 64'(div_by_zero), 64'(0));
    tick();
    run_op(32'd20, 32'd6, gq, gr, gdbz, lat, sb);
    check("post_rst_lat", 64'(lat), 64'(NORMAL_LAT));
    check("post_rst_q", 64'(gq), 64'(3));
    check("post_rst_r", 64'(gr), 64'(2));

    // Random back-to-back operations against a reference model
    for (int n = 0; n < N_RANDOM; n++) begin
      logic [W-1:0] ra, rb, eq, er;
      int           sel;
      ra  = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       rb = '0;
        1:       rb = 32'd1;
        2:       rb = W'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      if (rb == '0) begin
        eq = '1;
        er = ra;
      end else begin
        eq = ra / rb;
        er = ra % rb;
      end
      run_op(ra, rb, gq, gr, gdbz, lat, sb);
      check($sformatf("rnd%0d_q a=%0h b=%0h", n, ra, rb), 64'(gq), 64'(eq));
      check($sformatf("rnd%0d_r a=%0h b=%0h", n, ra, rb), 64'(gr), 64'(er));
      check($sformatf("rnd%0d_dbz", n), 64'(gdbz), 64'(rb == '0));
      if (rb != '0) begin
        check($sformatf("rnd%0d_identity", n), 64'(gq) * 64'(rb) + 64'(gr), 64'(ra));
        check($sformatf("rnd%0d_r_lt_b", n), 64'(gr < rb), 64'(1));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
